// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: ALU opcodes,
// sequencer state encoding and response flag bit positions.
package alu_op_sequencer_pkg;

   // 4-bit opcodes understood by the 32-bit ALU
   localparam logic [3:0] OP_NOOP         = 4'd0;
   localparam logic [3:0] OP_RESET        = 4'd1;
   localparam logic [3:0] OP_OR           = 4'd3;
   localparam logic [3:0] OP_AND          = 4'd5;
   localparam logic [3:0] OP_ADD          = 4'd6;
   localparam logic [3:0] OP_SUB          = 4'd8;
   localparam logic [3:0] OP_EQUAL        = 4'd12;
   localparam logic [3:0] OP_GREATER_THAN = 4'd13;
   localparam logic [3:0] OP_LESS_THAN    = 4'd14;
   localparam logic [3:0] OP_ERROR        = 4'd15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Bit positions inside rsp_flags = {illegal, overflow, carry, zero}
   localparam int FLAG_ZERO    = 0;
   localparam int FLAG_CARRY   = 1;
   localparam int FLAG_OVF     = 2;
   localparam int FLAG_ILLEGAL = 3;

   // True for opcodes whose ALU result is taken into the accumulator
   function automatic logic is_alu_op(input logic [3:0] op);
      case (op)
         OP_OR, OP_AND, OP_ADD, OP_SUB,
         OP_EQUAL, OP_GREATER_THAN, OP_LESS_THAN: is_alu_op = 1'b1;
         default:                                 is_alu_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of the command handshake, response handshake and ALU bus
// seen by the sequencer. slave = sequencer side, master = surroundings.
interface alu_op_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic        cmd_use_acc;

   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        alu_carry;
   logic        alu_overflow;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
      input  alu_result, alu_zero, alu_carry, alu_overflow,
      input  rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_op,
      output rsp_valid, rsp_result, rsp_flags
   );

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
      output alu_result, alu_zero, alu_carry, alu_overflow,
      output rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_op,
      input  rsp_valid, rsp_result, rsp_flags
   );
endinterface

// File: rtl/alu_op_sequencer_settle_counter.sv
// 4-bit loadable down-counter that times how long the ALU inputs are
// held. Stops at zero; tc is high while the count is zero.
module sequencer_settle_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       en,
   input  logic [3:0] load_val,
   output logic       tc
);

   logic [3:0] count_reg;

   // Load on command accept, otherwise count down while enabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= 4'd0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (en && (count_reg != 4'd0)) begin
         count_reg <= count_reg - 4'd1;
      end
   end

   assign tc = (count_reg == 4'd0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side stage in front of the 32-bit ALU: latches a command onto
// the ALU inputs, waits SETTLE_CYCLES, captures result and flags into the
// accumulator, then hands a response back.
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,   // legal range 1..15
   parameter int WIDTH         = 32   // fixed at 32
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_op_sequencer_if.slave    bus,
   output logic [15:0]          op_count
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t            state_reg;
   logic              cmd_ready_reg;
   logic [WIDTH-1:0]  alu_a_reg;
   logic [WIDTH-1:0]  alu_b_reg;
   logic [3:0]        alu_op_reg;
   logic [WIDTH-1:0]  acc_reg;
   logic [3:0]        flags_reg;
   logic              rsp_valid_reg;
   logic [15:0]       op_count_reg;

   logic [WIDTH-1:0]  acc_next;
   logic [3:0]        flags_next;
   logic              accept;
   logic              settle_done;

   assign accept = (state_reg == IDLE) && bus.cmd_valid && cmd_ready_reg;

   sequencer_settle_counter u_settle (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .en       (state_reg == EXEC),
      .load_val (SETTLE_LOAD),
      .tc       (settle_done)
   );

   // Accumulator/flag values to capture, decided by the held opcode
   always_comb begin
      acc_next   = acc_reg;
      flags_next = 4'b0000;
      case (alu_op_reg)
         OP_NOOP: begin
            flags_next[FLAG_ZERO] = (acc_reg == '0);
         end
         OP_RESET: begin
            acc_next              = '0;
            flags_next[FLAG_ZERO] = 1'b1;
         end
         default: begin
            if (is_alu_op(alu_op_reg)) begin
               acc_next               = bus.alu_result;
               flags_next[FLAG_ZERO]  = bus.alu_zero;
               flags_next[FLAG_CARRY] = bus.alu_carry;
               flags_next[FLAG_OVF]   = bus.alu_overflow;
            end else begin
               // ERROR and unassigned codes: ALU output is not trusted
               flags_next[FLAG_ILLEGAL] = 1'b1;
            end
         end
      endcase
   end

   // Sequencer FSM; cmd_ready rises one cycle after entering IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         cmd_ready_reg <= 1'b0;
         alu_a_reg     <= '0;
         alu_b_reg     <= '0;
         alu_op_reg    <= OP_NOOP;
         acc_reg       <= '0;
         flags_reg     <= 4'b0000;
         rsp_valid_reg <= 1'b0;
         op_count_reg  <= 16'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  alu_op_reg    <= bus.cmd_op;
                  alu_b_reg     <= bus.cmd_b;
                  alu_a_reg     <= bus.cmd_use_acc ? acc_reg : bus.cmd_a;
                  cmd_ready_reg <= 1'b0;
                  state_reg     <= EXEC;
               end else begin
                  cmd_ready_reg <= 1'b1;
               end
            end
            EXEC: begin
               if (settle_done) begin
                  acc_reg       <= acc_next;
                  flags_reg     <= flags_next;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  op_count_reg  <= op_count_reg + 16'd1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               cmd_ready_reg <= 1'b0;
               rsp_valid_reg <= 1'b0;
               state_reg     <= IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = cmd_ready_reg;
   assign bus.alu_a      = alu_a_reg;
   assign bus.alu_b      = alu_b_reg;
   assign bus.alu_op     = alu_op_reg;
   assign bus.rsp_valid  = rsp_valid_reg;
   assign bus.rsp_result = acc_reg;
   assign bus.rsp_flags  = flags_reg;
   assign op_count       = op_count_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 32-bit ALU on
// the ALU side of the bus.
module tb_alu_op_sequencer;
   import alu_op_sequencer_pkg::*;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] op_count;

   alu_op_sequencer_if bus ();

   alu_op_sequencer #(.SETTLE_CYCLES(S), .WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: carry is carry-out for ADD and borrow for SUB;
   // compares are unsigned; unused opcodes produce obvious garbage
   logic [32:0] wide;
   always_comb begin
      wide             = '0;
      bus.alu_overflow = 1'b0;
      case (bus.alu_op)
         OP_OR:  wide = {1'b0, bus.alu_a | bus.alu_b};
         OP_AND: wide = {1'b0, bus.alu_a & bus.alu_b};
         OP_ADD: begin
            wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (wide[31] != bus.alu_a[31]);
         end
         OP_SUB: begin
            wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) && (wide[31] != bus.alu_a[31]);
         end
         OP_EQUAL:        wide = {32'b0, bus.alu_a == bus.alu_b};
         OP_GREATER_THAN: wide = {32'b0, bus.alu_a >  bus.alu_b};
         OP_LESS_THAN:    wide = {32'b0, bus.alu_a <  bus.alu_b};
         default: begin
            wide             = 33'h1_DEAD_BEEF;
            bus.alu_overflow = 1'b1;
         end
      endcase
      bus.alu_result = wide[31:0];
      bus.alu_carry  = wide[32];
      bus.alu_zero   = (wide[31:0] == 32'd0);
   end

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        use_acc;
      logic [31:0] exp_a;
      logic [31:0] exp_res;
      logic [3:0]  exp_flags;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_cmd_ready();
      int waited = 0;
      while (!bus.cmd_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int lat;
      wait_cmd_ready();
      bus.cmd_op      = v.op;
      bus.cmd_a       = v.a;
      bus.cmd_b       = v.b;
      bus.cmd_use_acc = v.use_acc;
      bus.cmd_valid   = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_a       = $urandom;
      bus.cmd_b       = $urandom;
      bus.cmd_op      = 4'($urandom);
      bus.cmd_use_acc = ~v.use_acc;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            chk($sformatf("v%0d alu_a", idx), bus.alu_a, v.exp_a);
            chk($sformatf("v%0d alu_b", idx), bus.alu_b, v.b);
            chk($sformatf("v%0d alu_op", idx), 32'(bus.alu_op), 32'(v.op));
            chk($sformatf("v%0d busy", idx), 32'(bus.cmd_ready), 32'd0);
         end
      end while (!bus.rsp_valid && lat < 20);
      chk($sformatf("v%0d latency", idx), 32'(lat), 32'(S + 1));
      chk($sformatf("v%0d result", idx), bus.rsp_result, v.exp_res);
      chk($sformatf("v%0d flags", idx), 32'(bus.rsp_flags), 32'(v.exp_flags));
      chk($sformatf("v%0d count_before", idx), 32'(op_count), 32'(exp_cnt));
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      exp_cnt++;
      @(negedge clk);
      chk($sformatf("v%0d rsp_drop", idx), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("v%0d count_after", idx), 32'(op_count), 32'(exp_cnt));
      chk($sformatf("v%0d ready_gap", idx), 32'(bus.cmd_ready), 32'd0);
      $display("vec %0d op=%0d a=%h b=%h acc=%0d -> result=%h flags=%b count=%0d",
               idx, v.op, v.a, v.b, v.use_acc, bus.rsp_result, bus.rsp_flags, op_count);
   endtask

   initial begin
      int lat;
      int seen;
      vecs[0]  = '{OP_ADD,          32'd5,         32'd7,          1'b0, 32'd5,         32'd12,          4'b0000};
      vecs[1]  = '{OP_SUB,          32'd99,        32'd12,         1'b1, 32'd12,        32'd0,           4'b0001};
      vecs[2]  = '{OP_ADD,          32'h7FFFFFFF,  32'd1,          1'b0, 32'h7FFFFFFF,  32'h80000000,    4'b0100};
      vecs[3]  = '{OP_ADD,          32'd5,         32'd7,          1'b0, 32'd5,         32'd12,          4'b0000};
      vecs[4]  = '{4'd9,            32'd1,         32'd2,          1'b0, 32'd1,         32'd12,          4'b1000};
      vecs[5]  = '{OP_NOOP,         32'd3,         32'd4,          1'b0, 32'd3,         32'd12,          4'b0000};
      vecs[6]  = '{OP_OR,           32'd77,        32'h00000F00,   1'b1, 32'd12,        32'h00000F0C,    4'b0000};
      vecs[7]  = '{OP_AND,          32'hFF00FF00,  32'h0F0F0F0F,   1'b0, 32'hFF00FF00,  32'h0F000F00,    4'b0000};
      vecs[8]  = '{OP_SUB,          32'd3,         32'd5,          1'b0, 32'd3,         32'hFFFFFFFE,    4'b0010};
      vecs[9]  = '{OP_ADD,          32'hFFFFFFFF,  32'd1,          1'b0, 32'hFFFFFFFF,  32'd0,           4'b0011};
      vecs[10] = '{OP_EQUAL,        32'd7,         32'd7,          1'b0, 32'd7,         32'd1,           4'b0000};
      vecs[11] = '{OP_GREATER_THAN, 32'd3,         32'd9,          1'b0, 32'd3,         32'd0,           4'b0001};
      vecs[12] = '{OP_LESS_THAN,    32'd3,         32'd9,          1'b0, 32'd3,         32'd1,           4'b0000};
      vecs[13] = '{OP_ERROR,        32'd8,         32'd8,          1'b0, 32'd8,         32'd1,           4'b1000};
      vecs[14] = '{OP_RESET,        32'd8,         32'd8,          1'b0, 32'd8,         32'd0,           4'b0001};
      vecs[15] = '{OP_NOOP,         32'd0,         32'd0,          1'b0, 32'd0,         32'd0,           4'b0001};
      vecs[16] = '{4'd2,            32'd6,         32'd6,          1'b0, 32'd6,         32'd0,           4'b1000};

      bus.cmd_valid   = 1'b0;
      bus.cmd_op      = 4'd0;
      bus.cmd_a       = 32'd0;
      bus.cmd_b       = 32'd0;
      bus.cmd_use_acc = 1'b0;
      bus.rsp_ready   = 1'b0;
      exp_cnt         = 16'd0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("rst alu_a", bus.alu_a, 32'd0);
      chk("rst alu_b", bus.alu_b, 32'd0);
      chk("rst alu_op", 32'(bus.alu_op), 32'(OP_NOOP));
      chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst rsp_result", bus.rsp_result, 32'd0);
      chk("rst rsp_flags", 32'(bus.rsp_flags), 32'd0);
      chk("rst op_count", 32'(op_count), 32'd0);
      reset = 1'b1;
      #1;
      chk("rst release ready low", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      chk("rst first ready", 32'(bus.cmd_ready), 32'd1);
      $display("reset: cmd_ready=%0d op_count=%0d", bus.cmd_ready, op_count);

      // Table-driven vectors
      for (int i = 0; i < NVEC; i++) begin
         run_vec(i, vecs[i]);
      end

      // Backpressure with cmd_valid held high and cmd_a wiggling
      wait_cmd_ready();
      bus.cmd_op      = OP_ADD;
      bus.cmd_a       = 32'd5;
      bus.cmd_b       = 32'd7;
      bus.cmd_use_acc = 1'b0;
      bus.cmd_valid   = 1'b1;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         bus.cmd_a = $urandom;
      end while (!bus.rsp_valid && lat < 20);
      chk("bp rsp_valid", 32'(bus.rsp_valid), 32'd1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus.cmd_a = $urandom;
         chk($sformatf("bp%0d rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
         chk($sformatf("bp%0d cmd_ready", c), 32'(bus.cmd_ready), 32'd0);
         chk($sformatf("bp%0d result", c), bus.rsp_result, 32'd12);
         chk($sformatf("bp%0d flags", c), 32'(bus.rsp_flags), 32'd0);
         chk($sformatf("bp%0d alu_a", c), bus.alu_a, 32'd5);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      exp_cnt++;
      @(negedge clk);
      chk("bp count", 32'(op_count), 32'(exp_cnt));
      $display("backpressure: result=%h op_count=%0d", bus.rsp_result, op_count);

      // Reset while in EXEC: command is dropped, no response appears
      wait_cmd_ready();
      bus.cmd_op    = OP_ADD;
      bus.cmd_a     = 32'd1;
      bus.cmd_b     = 32'd2;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("mid alu_a before", bus.alu_a, 32'd1);
      reset = 1'b0;
      #1;
      exp_cnt = 16'd0;
      chk("mid alu_a", bus.alu_a, 32'd0);
      chk("mid alu_b", bus.alu_b, 32'd0);
      chk("mid alu_op", 32'(bus.alu_op), 32'(OP_NOOP));
      chk("mid cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("mid rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid rsp_result", bus.rsp_result, 32'd0);
      chk("mid op_count", 32'(op_count), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      bus.rsp_ready = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.rsp_valid) seen = 1;
      end
      bus.rsp_ready = 1'b0;
      chk("mid no response", 32'(seen), 32'd0);
      chk("mid op_count after", 32'(op_count), 32'd0);
      $display("mid-exec reset: response_seen=%0d op_count=%0d", seen, op_count);

      // Recovery from a clean accumulator after reset
      run_vec(NVEC, vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
